// File: rtl/l2_chan_arbmux.sv
// l2_chan_arbmux
//   N-to-1 valid/retry channel merger for the L2 <-> directory path.
//   Every input channel feeds a 2-entry skid buffer whose retry is a pure
//   flop output. A round-robin, packet-atomic arbiter drains those buffers
//   onto a single output channel that carries the source channel id.
//   The block also counts delivered packets and keeps a sticky error flag
//   for packets longer than MAXBEATS beats.
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   in_valid   : [NCH]    per-channel beat valid
//   in_retry   : [NCH]    per-channel back-pressure (high when the skid buffer is full)
//   in_data    : [NCH*DW] channel i occupies bits [i*DW +: DW]
//   in_last    : [NCH]    beat is the last beat of its packet
//   out_valid  : merged beat valid
//   out_retry  : downstream back-pressure
//   out_data   : [DW]     merged beat data
//   out_last   : merged beat is the last beat of its packet
//   out_chid   : [CIDW]   source channel of the current beat
//   stat_npkts : [16]     packets delivered, wraps at 2^16
//   proto_err  : sticky flag, set when a packet runs past MAXBEATS beats
module l2_chan_arbmux #(
  parameter  int NCH      = 4,
  parameter  int DW       = 64,
  parameter  int MAXBEATS = 8,
  localparam int CIDW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_retry,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_last,
  output logic              out_valid,
  input  logic              out_retry,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [CIDW-1:0]   out_chid,
  output logic [15:0]       stat_npkts,
  output logic              proto_err
);

  localparam int BCW = $clog2(MAXBEATS + 1) + 1;

  typedef enum logic {ST_FREE, ST_LOCKED} arb_state_t;

  arb_state_t                    r_state, w_state_nxt;
  logic [NCH-1:0][1:0]           r_occ;
  logic [NCH-1:0]                r_wptr, r_rptr;
  logic [NCH-1:0][1:0][DW-1:0]   r_mem_d;
  logic [NCH-1:0][1:0]           r_mem_l;
  logic [NCH-1:0][BCW-1:0]       r_cnt;
  logic [CIDW-1:0]               r_rr, r_lock_ch, r_hold_ch;
  logic                          r_hold;
  logic [15:0]                   r_npkts;
  logic                          r_err;

  logic [NCH-1:0]  w_push, w_pop, w_nonempty;
  logic [CIDW-1:0] w_gnt, w_cand, w_gnt_inc;
  logic            w_found, w_xfer, w_cnt_ovf;
  logic [DW-1:0]   w_head_d;
  logic            w_head_l;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      in_retry[i]   = (r_occ[i] == 2'd2);
      w_nonempty[i] = (r_occ[i] != 2'd0);
      w_push[i]     = in_valid[i] & ~in_retry[i];
    end
  end

  // Priority: a held beat stays frozen, then the locked channel, otherwise a
  // round-robin search starting at r_rr.
  always_comb begin
    w_gnt   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    if (r_hold) begin
      w_gnt   = r_hold_ch;
      w_found = w_nonempty[r_hold_ch];
    end else if (r_state == ST_LOCKED) begin
      w_gnt   = r_lock_ch;
      w_found = w_nonempty[r_lock_ch];
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        w_cand = CIDW'((32'(r_rr) + k) % NCH);
        if (!w_found && w_nonempty[w_cand]) begin
          w_gnt   = w_cand;
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_head_d  = r_mem_d[w_gnt][r_rptr[w_gnt]];
    w_head_l  = r_mem_l[w_gnt][r_rptr[w_gnt]];
    out_valid = w_found;
    out_data  = w_found ? w_head_d : '0;
    out_last  = w_found & w_head_l;
    out_chid  = w_found ? w_gnt : '0;
    w_xfer    = w_found & ~out_retry;
    w_gnt_inc = (w_gnt == CIDW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
    w_cnt_ovf = ({1'b0, r_cnt[w_gnt]} + 1'b1) > (BCW + 1)'(MAXBEATS);
    for (int unsigned i = 0; i < NCH; i++) begin
      w_pop[i] = w_xfer & (w_gnt == CIDW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = out_last ? ST_FREE : ST_LOCKED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_FREE;
      r_lock_ch <= '0;
      r_hold    <= 1'b0;
      r_hold_ch <= '0;
      r_rr      <= '0;
      r_npkts   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= out_valid & out_retry;
      r_hold_ch <= w_gnt;
      if (w_xfer) begin
        if (out_last) begin
          r_rr    <= w_gnt_inc;
          r_npkts <= r_npkts + 16'd1;
        end else begin
          r_lock_ch <= w_gnt;
        end
        if (w_cnt_ovf) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_mem_d <= '0;
      r_mem_l <= '0;
      r_cnt   <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_occ[i] <= r_occ[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
        if (w_push[i]) begin
          r_mem_d[i][r_wptr[i]] <= in_data[i*DW +: DW];
          r_mem_l[i][r_wptr[i]] <= in_last[i];
          r_wptr[i]             <= ~r_wptr[i];
        end
        if (w_pop[i]) begin
          r_rptr[i] <= ~r_rptr[i];
          // Saturate so an over-long packet cannot wrap back below MAXBEATS.
          if (out_last) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] != '1) begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign stat_npkts = r_npkts;
  assign proto_err  = r_err;

endmodule

// File: tb/tb_l2_chan_arbmux.sv
// Testbench for l2_chan_arbmux: cycle-exact vector table for the single-packet
// and fairness cases, then reactive sender sequences for atomicity,
// back-pressure, protocol error and reset mid-packet.
module tb_l2_chan_arbmux;
  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int MXB = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    in_valid, in_retry, in_last;
  logic [NCH*DW-1:0] in_data;
  logic              out_valid, out_retry, out_last;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_chid;
  logic [15:0]       stat_npkts;
  logic              proto_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_chan_arbmux #(.NCH(NCH), .DW(DW), .MAXBEATS(MXB)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_retry(in_retry), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_retry(out_retry), .out_data(out_data),
    .out_last(out_last), .out_chid(out_chid),
    .stat_npkts(stat_npkts), .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            rst_n;
    logic [3:0]      v;
    logic [3:0]      l;
    logic [3:0][63:0] d;
    logic            oretry;
    logic [3:0]      e_ir;
    logic            e_ov;
    logic [63:0]     e_od;
    logic            e_ol;
    logic [1:0]      e_ch;
    logic [15:0]     e_np;
    logic            e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_n, input logic [3:0] v, input logic [3:0] l,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3,
                              input logic oretry, input logic [3:0] e_ir, input logic e_ov,
                              input logic [63:0] e_od, input logic e_ol, input logic [1:0] e_ch,
                              input logic [15:0] e_np, input logic e_err);
    vec_t r;
    r.rst_n = rst_n; r.v = v; r.l = l;
    r.d[0] = d0; r.d[1] = d1; r.d[2] = d2; r.d[3] = d3;
    r.oretry = oretry; r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od;
    r.e_ol = e_ol; r.e_ch = e_ch; r.e_np = e_np; r.e_err = e_err;
    return r;
  endfunction

  // Reactive senders, a model of skid occupancy and a log of output transfers.
  logic [63:0]    src_d [NCH][16];
  logic           src_l [NCH][16];
  int             src_len [NCH];
  int             src_idx [NCH];
  int             mocc [NCH];
  logic [NCH-1:0] xin;
  logic           xout;
  logic [1:0]     log_ch [64];
  logic [63:0]    log_d [64];
  logic           log_l [64];
  int             log_c [64];
  int             log_n;
  int             cyc;

  task automatic drive_src();
    for (int i = 0; i < NCH; i++) begin
      in_valid[i] = src_idx[i] < src_len[i];
      in_data[i*DW +: DW] = in_valid[i] ? src_d[i][src_idx[i]] : '0;
      in_last[i] = in_valid[i] ? src_l[i][src_idx[i]] : 1'b0;
    end
  endtask

  task automatic load(input int ch, input int n, input logic [63:0] base, input logic last_end);
    for (int k = 0; k < n; k++) begin
      src_d[ch][src_len[ch]] = base + 64'(k);
      src_l[ch][src_len[ch]] = last_end && (k == n - 1);
      src_len[ch]++;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NCH; i++) begin
      src_len[i] = 0; src_idx[i] = 0; mocc[i] = 0;
    end
    log_n = 0;
    drive_src();
  endtask

  task automatic hard_reset();
    reset = 1'b0;
    out_retry = 1'b0;
    clear_src();
    @(posedge clk); #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("c%0d_in_retry%0d", cyc, i), 64'(in_retry[i]), 64'(mocc[i] == 2));
    xin  = in_valid & ~in_retry;
    xout = out_valid & ~out_retry;
    if (xout && log_n < 64) begin
      log_ch[log_n] = out_chid; log_d[log_n] = out_data;
      log_l[log_n] = out_last; log_c[log_n] = cyc;
      log_n++;
    end
  endtask

  task automatic advance();
    @(posedge clk); #1;
    for (int i = 0; i < NCH; i++) begin
      if (xin[i]) begin src_idx[i]++; mocc[i]++; end
    end
    if (xout) mocc[log_ch[log_n-1]]--;
    drive_src();
    cyc++;
  endtask

  initial begin
    int p;
    reset = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_retry = 1'b0;
    cyc = 0; clear_src();

    // Test 1: single 3-beat packet on ch0.
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 64'hA1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 64'hA2, 0, 0, 0, 0, 4'b0000, 1, 64'hA1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 64'hA3, 0, 0, 0, 0, 4'b0000, 1, 64'hA2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 64'hA3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 0));
    // Reset between tests brings rr_ptr back to 0.
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    // Test 2: ch1 and ch3 each offer four 1-beat packets every cycle.
    tbl.push_back(mk(1, 4'b1010, 4'b1010, 0, 64'h1001, 0, 64'h3001, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, 0, 64'h1002, 0, 64'h3002, 0, 4'b0000, 1, 64'h1001, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, 0, 64'h1003, 0, 64'h3003, 0, 4'b1000, 1, 64'h3001, 1, 3, 1, 0));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, 0, 64'h1004, 0, 64'h3003, 0, 4'b0010, 1, 64'h1002, 1, 1, 2, 0));
    tbl.push_back(mk(1, 4'b1010, 4'b1010, 0, 64'h1004, 0, 64'h3004, 0, 4'b1000, 1, 64'h3002, 1, 3, 3, 0));
    tbl.push_back(mk(1, 4'b1000, 4'b1000, 0, 0, 0, 64'h3004, 0, 4'b0010, 1, 64'h1003, 1, 1, 4, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b1000, 1, 64'h3003, 1, 3, 5, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 64'h1004, 1, 1, 6, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 64'h3004, 1, 3, 7, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 8, 0));

    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < tbl.size(); k++) begin
      reset = tbl[k].rst_n;
      in_valid = tbl[k].v; in_last = tbl[k].l; in_data = tbl[k].d;
      out_retry = tbl[k].oretry;
      @(negedge clk);
      chk($sformatf("v%0d_in_retry", k), 64'(in_retry), 64'(tbl[k].e_ir));
      chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].e_ov));
      chk($sformatf("v%0d_out_data", k), out_data, tbl[k].e_od);
      chk($sformatf("v%0d_out_last", k), 64'(out_last), 64'(tbl[k].e_ol));
      chk($sformatf("v%0d_out_chid", k), 64'(out_chid), 64'(tbl[k].e_ch));
      chk($sformatf("v%0d_npkts", k), 64'(stat_npkts), 64'(tbl[k].e_np));
      chk($sformatf("v%0d_proto_err", k), 64'(proto_err), 64'(tbl[k].e_err));
      @(posedge clk); #1;
    end

    // Test 3: 8-beat ch0 line and a 1-beat ch1 packet start together.
    hard_reset();
    load(0, 8, 64'h0A00, 1'b1); load(1, 1, 64'h1B00, 1'b1); drive_src();
    for (int k = 0; k < 60 && log_n < 9; k++) begin sample(); advance(); end
    chk("t3_beats", 64'(log_n), 64'd9);
    for (int j = 0; j < 9 && j < log_n; j++) begin
      chk($sformatf("t3_chid%0d", j), 64'(log_ch[j]), (j < 8) ? 64'd0 : 64'd1);
      chk($sformatf("t3_data%0d", j), log_d[j], (j < 8) ? 64'h0A00 + 64'(j) : 64'h1B00);
      chk($sformatf("t3_last%0d", j), 64'(log_l[j]), 64'(j >= 7));
      if (j < 8) chk($sformatf("t3_cycle%0d", j), 64'(log_c[j]), 64'(log_c[0] + j));
    end
    @(negedge clk);
    chk("t3_npkts", 64'(stat_npkts), 64'd2);

    // Test 4: downstream retry for 5 cycles while ch2 streams 6 beats.
    hard_reset();
    load(2, 6, 64'h2C00, 1'b1); drive_src();
    for (int k = 0; k < 30; k++) begin
      sample();
      if (k >= 1 && k <= 5) begin
        chk($sformatf("t4_hold_valid%0d", k), 64'(out_valid), 64'd1);
        chk($sformatf("t4_hold_data%0d", k), out_data, 64'h2C00);
        chk($sformatf("t4_hold_chid%0d", k), 64'(out_chid), 64'd2);
      end
      if (k >= 2 && k <= 5) chk($sformatf("t4_retry2_%0d", k), 64'(in_retry[2]), 64'd1);
      advance();
      out_retry = (k + 1 >= 1) && (k + 1 <= 5);
    end
    chk("t4_beats", 64'(log_n), 64'd6);
    for (int j = 0; j < 6 && j < log_n; j++)
      chk($sformatf("t4_data%0d", j), log_d[j], 64'h2C00 + 64'(j));

    // Test 5: ch3 sends 9 beats without last.
    hard_reset();
    load(3, 9, 64'h3D00, 1'b0); drive_src();
    for (int k = 0; k < 30; k++) begin
      p = log_n;
      sample();
      chk($sformatf("t5_err%0d", k), 64'(proto_err), 64'(p >= 9));
      advance();
    end
    chk("t5_beats", 64'(log_n), 64'd9);
    @(negedge clk);
    chk("t5_locked_idle", 64'(out_valid), 64'd0);

    // Test 6: reset asserted after beat 4 of an 8-beat ch0 packet.
    hard_reset();
    load(0, 8, 64'h0E00, 1'b1); drive_src();
    for (int k = 0; k < 30 && log_n < 4; k++) begin sample(); advance(); end
    chk("t6_pre_beats", 64'(log_n), 64'd4);
    reset = 1'b0;
    clear_src();
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_out_data", out_data, 64'd0);
    chk("t6_rst_out_last", 64'(out_last), 64'd0);
    chk("t6_rst_out_chid", 64'(out_chid), 64'd0);
    chk("t6_rst_in_retry", 64'(in_retry), 64'd0);
    chk("t6_rst_npkts", 64'(stat_npkts), 64'd0);
    chk("t6_rst_proto_err", 64'(proto_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc = 0;
    load(1, 1, 64'h1F00, 1'b1); drive_src();
    for (int k = 0; k < 10; k++) begin sample(); advance(); end
    chk("t6_post_beats", 64'(log_n), 64'd1);
    chk("t6_post_chid", 64'(log_ch[0]), 64'd1);
    chk("t6_post_data", log_d[0], 64'h1F00);
    @(negedge clk);
    chk("t6_post_npkts", 64'(stat_npkts), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
